c2h_queue_scheduler: RTL
========================

# c2h_queue_scheduler

Per-queue credit scheduler that sequences the C2H traffic generator across multiple QDMA queues. It accumulates descriptor credits per queue and picks the next eligible queue round-robin. It then issues one packet request per grant to the generator and enforces the per-packet pacing gap and the total packet count. It sits between the credit-update path and the generator's packet-start/packet-done handshake.

## Interface
- NUM_Q, 4: maximum number of queues tracked (credit counters instantiated).
- TM_DSC_BITS, 16: credit counter and credit_in width.
- QID_W, 11: queue id width.

Ports:
- axi_aclk  in  1  clock.
- axi_aresetn  in  1  reset; asynchronous, active-low (one clock domain only).
- start  in  1  level; a rising edge (sampled) begins a run.
- abort  in  1  synchronous stop; returns the block to IDLE and clears credits.
- num_pkt  in  16  packets per run.
- qid_base  in  QID_W  first queue id.
- num_queue  in  $clog2(NUM_Q)+1  active queues; 0 is treated as 1, values >NUM_Q are treated as NUM_Q.
- cycles_per_pkt  in  32  minimum spacing between request handshakes.
- credit_updt  in  1  credit_in/credit_qid valid.
- credit_in  in  TM_DSC_BITS  credits to add.
- credit_qid  in  QID_W  queue receiving the credits.
- pkt_req_valid  out  1  packet request to the generator.
- pkt_req_qid  out  QID_W  queue for the request; stable while valid.
- pkt_req_ready  in  1  generator accepts the request.
- pkt_done  in  1  one-cycle pulse when the generator's last beat is accepted.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run completion.
- credit_err  out  1  one-cycle pulse: the update was out of range or saturated.
- pkt_count  out  16  requests handshaked in the current run.

## Operation
- Queue index i = credit_qid − qid_base. Valid when 0 ≤ i < num_queue (effective).
- On credit_updt with a valid i: credit[i] += credit_in, saturating at all-ones. Saturation pulses credit_err.
- On credit_updt with an invalid i: the update is ignored and credit_err pulses.
- Credits accumulate in every state, including IDLE. They are cleared only by reset or abort.
- States:
  - IDLE: wait for a start rising edge. On the edge, set pkt_count←0 and rr_ptr←0.
    - If num_pkt==0: go to FIN.
    - Else: go to ARB.
  - ARB: scan queues starting at rr_ptr, wrapping modulo num_queue, for the first queue with credit>0.
    - If found: register sel, set pkt_req_qid←qid_base+sel, go to ISSUE.
    - Else: stay in ARB.
  - ISSUE: pkt_req_valid=1. On pkt_req_ready:
    - credit[sel]−1.
    - pkt_count+1.
    - rr_ptr←(sel+1) mod num_queue.
    - gap_cnt←0, done_seen←0.
    - Go to WAIT.
  - WAIT: gap_cnt increments each cycle (saturating). A pkt_done pulse sets done_seen. Exit only when done_seen is set (including a pulse in the same cycle) and gap_cnt ≥ cycles_per_pkt−3 (saturating at 0).
    - If pkt_count==num_pkt: go to FIN.
    - Else: go to ARB.
  - FIN: done=1 for one cycle, then go to IDLE.
- A simultaneous credit update and grant decrement on the same queue nets credit+credit_in−1 (saturated).
- pkt_done outside WAIT is ignored.
- start deasserting mid-run has no effect; only abort stops a run.
- abort in any state: next cycle is IDLE, pkt_req_valid=0, all credits=0, pkt_count held, done not pulsed.
- busy=1 in ARB, ISSUE and WAIT.

## Timing
- Reset values: pkt_req_valid 0, pkt_req_qid 0, busy 0, done 0, credit_err 0, pkt_count 0, all credits 0, state IDLE.
- All outputs are registered.
- Start edge sampled at cycle T: ARB at T+1, pkt_req_valid at T+2 when credit is already present.
- Handshake spacing: next handshake is no earlier than max(cycles_per_pkt, 3) cycles after the previous one, and no earlier than 2 cycles after pkt_done.
- A credit update at cycle C is visible to the ARB scan at C+1.
- credit_err is asserted the cycle after the offending update.
- Once pkt_req_valid is high it stays high with qid unchanged until ready; there is no retraction except via abort.
- done pulses 1 cycle after the WAIT exit on the final packet.

## Test plan
- num_queue=4, qid_base=8, 10 credits per queue, num_pkt=8, cycles_per_pkt=0, pkt_done 1 cycle after each handshake → qids 8,9,10,11,8,9,10,11; handshake spacing 3 cycles; done pulses once; every queue has 8 credits remaining.
- Same setup with cycles_per_pkt=20 → consecutive handshakes exactly 20 cycles apart.
- Only queue 10 has credits (2), num_pkt=4 → two grants to 10, then the block stalls in ARB with busy=1; adding 1 credit to qid 9 → next grant goes to qid 9.
- Credit to qid 12 with num_queue=4, qid_base=8 → credit_err pulse, no credit change. Credit 0xFFFF to a queue holding 5 → saturates at 0xFFFF with credit_err.
- pkt_req_ready held low for 7 cycles → valid and qid stable for all 7 cycles. abort during WAIT → IDLE the next cycle, credits 0, no done pulse.
- Async reset asserted mid-ISSUE → all outputs immediately at reset values. num_pkt=0 → start yields a done pulse at T+2 with no request issued.

Source files
------------

// File: rtl/c2h_queue_scheduler_if.sv
// Packet-request channel between the queue scheduler (master) and the C2H generator (slave).
// valid/ready: a request transfers on a cycle with pkt_req_valid and pkt_req_ready both high;
// once raised, valid and qid hold until that cycle. pkt_done is a one-cycle pulse from the generator.
interface c2h_queue_scheduler_if #(
  parameter int QID_W = 11
);
  logic             pkt_req_valid;
  logic [QID_W-1:0] pkt_req_qid;
  logic             pkt_req_ready;
  logic             pkt_done;

  modport master (output pkt_req_valid, output pkt_req_qid, input pkt_req_ready, input pkt_done);
  modport slave  (input pkt_req_valid, input pkt_req_qid, output pkt_req_ready, output pkt_done);
endinterface

// File: rtl/c2h_queue_scheduler.sv
// Per-queue credit scheduler: accumulates descriptor credits, grants queues round-robin,
// issues one generator request per grant and paces requests by gap and packet count.
module c2h_queue_scheduler #(
  parameter int NUM_Q       = 4,
  parameter int TM_DSC_BITS = 16,
  parameter int QID_W       = 11
) (
  input  logic                         axi_aclk,
  input  logic                         axi_aresetn,
  input  logic                         start,
  input  logic                         abort,
  input  logic [15:0]                  num_pkt,
  input  logic [QID_W-1:0]             qid_base,
  input  logic [$clog2(NUM_Q):0]       num_queue,
  input  logic [31:0]                  cycles_per_pkt,
  input  logic                         credit_updt,
  input  logic [TM_DSC_BITS-1:0]       credit_in,
  input  logic [QID_W-1:0]             credit_qid,
  c2h_queue_scheduler_if.master        req,
  output logic                         busy,
  output logic                         done,
  output logic                         credit_err,
  output logic [15:0]                  pkt_count,
  output logic [2:0]                   dbg_state,  // 0 IDLE, 1 ARB, 2 ISSUE, 3 WAIT, 4 FIN
  output logic [NUM_Q*TM_DSC_BITS-1:0] dbg_credit
);
  localparam int PTR_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
  localparam int NQ_W  = $clog2(NUM_Q) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t                 state;
  logic [TM_DSC_BITS-1:0] credit     [NUM_Q];
  logic [TM_DSC_BITS-1:0] credit_nxt [NUM_Q];
  logic [TM_DSC_BITS:0]   sum        [NUM_Q];
  logic [NQ_W:0]          scan_idx   [NUM_Q];
  logic [NUM_Q-1:0]       credit_sat;
  logic                   start_q, done_seen, req_valid;
  logic [QID_W-1:0]       req_qid, upd_idx;
  logic [PTR_W-1:0]       rr_ptr, sel, pick, rr_nxt;
  logic [NQ_W-1:0]        nq;
  logic [NQ_W:0]          sel_inc;
  logic [31:0]            gap_cnt, gap_min;
  logic                   upd_ok, grant, found, wait_exit;

  assign req.pkt_req_valid = req_valid;
  assign req.pkt_req_qid   = req_qid;
  assign dbg_state         = state;

  always_comb begin
    if (num_queue == '0)                  nq = NQ_W'(1);
    else if (num_queue > NQ_W'(NUM_Q))    nq = NQ_W'(NUM_Q);
    else                                  nq = num_queue;
  end

  // Negative indices wrap to large unsigned values and fall out of range naturally.
  assign upd_idx   = credit_qid - qid_base;
  assign upd_ok    = credit_updt && (upd_idx < QID_W'(nq));
  assign grant     = (state == S_ISSUE) && req.pkt_req_ready;
  assign gap_min   = (cycles_per_pkt < 32'd3) ? 32'd0 : cycles_per_pkt - 32'd3;
  assign wait_exit = (state == S_WAIT) && (done_seen || req.pkt_done) && (gap_cnt >= gap_min);
  assign sel_inc   = (NQ_W+1)'(sel) + (NQ_W+1)'(1);
  assign rr_nxt    = (sel_inc >= (NQ_W+1)'(nq)) ? '0 : sel_inc[PTR_W-1:0];

  always_comb begin
    dbg_credit = '0;
    for (int q = 0; q < NUM_Q; q++) begin
      sum[q] = {1'b0, credit[q]};
      if (upd_ok && (upd_idx == QID_W'(q))) sum[q] = sum[q] + {1'b0, credit_in};
      if (grant && (sel == PTR_W'(q)))      sum[q] = sum[q] - (TM_DSC_BITS+1)'(1);
      credit_sat[q] = sum[q][TM_DSC_BITS];
      credit_nxt[q] = credit_sat[q] ? '1 : sum[q][TM_DSC_BITS-1:0];
      dbg_credit[q*TM_DSC_BITS +: TM_DSC_BITS] = credit[q];
    end
  end

  // First queue with credit, scanning from rr_ptr and wrapping at the effective queue count.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_Q; k++) begin
      scan_idx[k] = (NQ_W+1)'(rr_ptr) + (NQ_W+1)'(k);
      if (scan_idx[k] >= (NQ_W+1)'(nq)) scan_idx[k] = scan_idx[k] - (NQ_W+1)'(nq);
      if (!found && ((NQ_W+1)'(k) < (NQ_W+1)'(nq)) && (scan_idx[k] < (NQ_W+1)'(nq)) &&
          (credit[scan_idx[k][PTR_W-1:0]] != '0)) begin
        found = 1'b1;
        pick  = scan_idx[k][PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int q = 0; q < NUM_Q; q++) credit[q] <= '0;
      credit_err <= 1'b0;
    end else if (abort) begin
      for (int q = 0; q < NUM_Q; q++) credit[q] <= '0;
      credit_err <= 1'b0;
    end else begin
      for (int q = 0; q < NUM_Q; q++) credit[q] <= credit_nxt[q];
      credit_err <= credit_updt && (!upd_ok || (|credit_sat));
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      req_valid <= 1'b0;
      req_qid   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pkt_count <= '0;
      rr_ptr    <= '0;
      sel       <= '0;
      gap_cnt   <= '0;
      done_seen <= 1'b0;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        req_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start && !start_q) begin
            pkt_count <= '0;
            rr_ptr    <= '0;
            if (num_pkt == '0) state <= S_FIN;
            else begin
              state <= S_ARB;
              busy  <= 1'b1;
            end
          end
          S_ARB: if (found) begin
            sel       <= pick;
            req_qid   <= qid_base + QID_W'(pick);
            req_valid <= 1'b1;
            state     <= S_ISSUE;
          end
          S_ISSUE: if (req.pkt_req_ready) begin
            req_valid <= 1'b0;
            pkt_count <= pkt_count + 16'd1;
            rr_ptr    <= rr_nxt;
            gap_cnt   <= '0;
            done_seen <= 1'b0;
            state     <= S_WAIT;
          end
          S_WAIT: begin
            if (gap_cnt != '1) gap_cnt <= gap_cnt + 32'd1;
            if (req.pkt_done)  done_seen <= 1'b1;
            if (wait_exit) begin
              if (pkt_count == num_pkt) begin
                state <= S_FIN;
                busy  <= 1'b0;
              end else begin
                state <= S_ARB;
              end
            end
          end
          S_FIN: begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
